// File: rtl/plinko_pkg.sv
// Shared definitions for the plinko stimulus path: widths, dropper state
// encoding and the 7-bit LFSR recurrence.
package plinko_pkg;

  localparam int RAND_W   = 7;
  localparam int NUM_BINS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drop_state_e;

  // Taps for x^7 + x^6 + 1 on a left-shifting register: bits 6 and 5.
  localparam logic [RAND_W-1:0] LFSR_TAPS     = 7'h60;
  localparam logic [RAND_W-1:0] ZERO_SEED_SUB = 7'h01;

  function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] cur);
    return {cur[RAND_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ball_dropper_if.sv
// Handshake/data bundle between the run controller and the dropper.
interface ball_dropper_if;
  import plinko_pkg::*;

  logic              start;
  logic              pause;
  logic              seedLoad;
  logic [RAND_W-1:0] seedIn;
  logic [RAND_W-1:0] randChoice;
  logic              ballValid;
  logic [7:0]        ballsDropped;
  logic              busy;
  logic              done;

  modport master (
    output start, pause, seedLoad, seedIn,
    input  randChoice, ballValid, ballsDropped, busy, done
  );

  modport slave (
    input  start, pause, seedLoad, seedIn,
    output randChoice, ballValid, ballsDropped, busy, done
  );

endinterface

// File: rtl/lfsr7.sv
// Maximal-length 7-bit Fibonacci LFSR with step enable and seed load.
// A zero load value is replaced so the register can never lock up.
module lfsr7
  import plinko_pkg::*;
#(
  parameter logic [RAND_W-1:0] SEED = 7'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [RAND_W-1:0] loadVal,
  output logic [RAND_W-1:0] q
);

  logic [RAND_W-1:0] q_q;
  logic [RAND_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (loadVal == '0) ? ZERO_SEED_SUB : loadVal;
    end else if (advance) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ball_dropper.sv
// Meters NUM_BALLS pseudo-random balls per run into the plinko board;
// ballValid doubles as the board's advance enable.
module ball_dropper
  import plinko_pkg::*;
#(
  parameter int                NUM_BALLS = 80,
  parameter logic [RAND_W-1:0] SEED      = 7'h5A
) (
  input logic           clk,
  input logic           rst,
  ball_dropper_if.slave bus
);

  localparam logic [7:0] LAST_CNT = 8'(NUM_BALLS - 1);

  drop_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ball_vld;
  logic              run_ok;
  logic              busy_w;
  logic              done_w;
  logic              seed_ld;
  logic [RAND_W-1:0] lfsr_q;

  // Seeding and start requests are only honoured outside a run.
  assign run_ok  = (state_q != ST_RUN);
  assign seed_ld = bus.seedLoad && run_ok;

  lfsr7 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .advance(ball_vld),
    .load   (seed_ld),
    .loadVal(bus.seedIn),
    .q      (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_RUN;
      ST_RUN:           if (ball_vld && (cnt_q == LAST_CNT)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (run_ok && bus.start) begin
      cnt_d = '0;
    end else if (ball_vld) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    ball_vld = 1'b0;
    busy_w   = 1'b0;
    done_w   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        ball_vld = ~bus.pause;
        busy_w   = 1'b1;
      end
      ST_DONE: done_w = 1'b1;
      default: ;
    endcase
  end

  assign bus.randChoice   = lfsr_q;
  assign bus.ballValid    = ball_vld;
  assign bus.ballsDropped = cnt_q;
  assign bus.busy         = busy_w;
  assign bus.done         = done_w;

endmodule

// File: tb/tb_ball_dropper.sv
// Directed bench for ball_dropper: an 80-ball instance for sequencing,
// pause, ignored inputs and reset, plus a 127-ball instance for full period.
module tb_ball_dropper;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_dropper_if a ();
  ball_dropper_if b ();

  ball_dropper #(.NUM_BALLS(80), .SEED(7'h5A)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );
  ball_dropper #(.NUM_BALLS(127), .SEED(7'h5A)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  logic [6:0] hand [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
  logic [6:0] model;
  logic [127:0] seen;
  int nvalid;
  int bound;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a.start = 0; a.pause = 0; a.seedLoad = 0; a.seedIn = '0;
    b.start = 0; b.pause = 0; b.seedLoad = 0; b.seedIn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_rand",  a.randChoice, 7'h5A);
    chk("rst_valid", a.ballValid, 0);
    chk("rst_busy",  a.busy, 0);
    chk("rst_done",  a.done, 0);
    chk("rst_cnt",   a.ballsDropped, 0);
    chk("rst_b_rand", b.randChoice, 7'h5A);

    // Zero seed substitutes 7'h01
    a.seedLoad = 1; a.seedIn = 7'h00;
    @(negedge clk);
    a.seedLoad = 0;
    chk("zero_seed", a.randChoice, 7'h01);
    chk("idle_valid", a.ballValid, 0);

    // Seed 01 and start together
    a.seedLoad = 1; a.seedIn = 7'h01; a.start = 1;
    @(negedge clk);
    a.seedLoad = 0; a.start = 0;
    model = 7'h01;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      chk("run_valid", a.ballValid, 1);
      chk("run_busy", a.busy, 1);
      chk("run_seq", a.randChoice, model);
      if (i < 8) chk("hand_seq", a.randChoice, hand[i]);
      chk("run_cnt", a.ballsDropped, nvalid);
      model = step(model);
      nvalid++;
      @(negedge clk);
    end

    // Pause for 3 cycles after ball 10
    for (int i = 0; i < 3; i++) begin
      a.pause = 1;
      #1;
      chk("pause_valid", a.ballValid, 0);
      chk("pause_rand", a.randChoice, model);
      chk("pause_cnt", a.ballsDropped, 10);
      @(negedge clk);
    end
    a.pause = 0;
    #1;
    chk("resume_seq", a.randChoice, model);

    // Remainder of run; seedLoad 33 and start mid-run must be ignored
    bound = 200;
    while (a.ballValid && bound > 0) begin
      chk("run_seq", a.randChoice, model);
      chk("run_cnt", a.ballsDropped, nvalid);
      a.seedLoad = (nvalid == 20);
      a.seedIn   = 7'h33;
      a.start    = (nvalid == 25);
      model = step(model);
      nvalid++;
      bound--;
      @(negedge clk);
    end
    a.seedLoad = 0; a.start = 0;
    chk("valid_cycles", nvalid, 80);
    chk("done_flag", a.done, 1);
    chk("done_busy", a.busy, 0);
    chk("done_valid", a.ballValid, 0);
    chk("done_cnt", a.ballsDropped, 80);
    @(negedge clk);
    chk("done_hold", a.done, 1);
    chk("done_rand", a.randChoice, model);

    // DONE -> RUN continues the sequence without reseeding
    a.start = 1;
    @(negedge clk);
    a.start = 0;
    chk("rerun_done", a.done, 0);
    chk("rerun_busy", a.busy, 1);
    chk("rerun_cnt", a.ballsDropped, 0);
    for (int i = 0; i < 40; i++) begin
      chk("rerun_seq", a.randChoice, model);
      model = step(model);
      @(negedge clk);
    end
    chk("pre_rst_cnt", a.ballsDropped, 40);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a.ballValid, 0);
    chk("arst_busy", a.busy, 0);
    chk("arst_rand", a.randChoice, 7'h5A);
    chk("arst_cnt", a.ballsDropped, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", a.ballValid, 0);
    a.start = 1;
    @(negedge clk);
    a.start = 0;
    chk("post_rst_valid", a.ballValid, 1);
    chk("post_rst_first", a.randChoice, 7'h5A);

    // Full period on the 127-ball instance
    b.start = 1;
    @(negedge clk);
    b.start = 0;
    seen = '0;
    nvalid = 0;
    bound = 300;
    while (b.ballValid && bound > 0) begin
      chk("b_nonzero", (b.randChoice != 7'h00), 1);
      chk("b_distinct", seen[b.randChoice], 0);
      seen[b.randChoice] = 1'b1;
      nvalid++;
      bound--;
      @(negedge clk);
    end
    chk("b_count", nvalid, 127);
    chk("b_done", b.done, 1);
    chk("b_cnt", b.ballsDropped, 127);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_dropper.md
Name: ball_dropper

Overview:
Upstream stimulus stage for plinkoboard. Generates the 7-bit pseudo-random randChoice stream from a maximal-length LFSR, one ball per clock. It meters a fixed number of balls per run and flags completion. ballValid qualifies each randChoice value. Integration uses ballValid as the plinkoboard advance enable, so paused or idle cycles drop no ball.

Parameters:
NUM_BALLS, 80, balls dropped per run; legal range 1..255.
SEED, 7'h5A, LFSR reset value; must be nonzero.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle run request
pause  input  1  level; freezes the run while high
seedLoad  input  1  loads seedIn into the LFSR
seedIn  input  7  new seed value
randChoice  output  7  current LFSR state, fed to plinkoboard
ballValid  output  1  high when randChoice is a ball this cycle
ballsDropped  output  8  balls issued in the current run
busy  output  1  high in RUN
done  output  1  high in DONE until the next start

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE; LFSR=SEED; randChoice=SEED; ballValid=0; ballsDropped=0; busy=0; done=0.
- LFSR: Fibonacci form, polynomial x^7+x^6+1, period 127.
  - next = {q[5:0], q[6]^q[5]}.
  - Advances only on an edge where ballValid=1.
  - randChoice always equals q.
- States: IDLE, RUN, DONE.
- IDLE/DONE, seedLoad=1: on the next edge, q=seedIn. A seedIn of 0 loads 7'h01 instead, so the LFSR never locks up.
- IDLE/DONE, start=1: on the next edge, state=RUN, ballsDropped=0, done=0.
  - If seedLoad and start are high in the same cycle, both take effect; the first ball uses the new seed.
  - DONE->RUN does not reseed; the sequence continues from the current q.
- RUN:
  - ballValid = ~pause (combinational from state and pause); busy=1.
  - Each edge with ballValid=1: q advances and ballsDropped increments.
  - The first ball of a run is the current q, i.e. SEED or the loaded seed.
- RUN, pause=1: ballValid=0; q and ballsDropped hold. Resume continues the sequence with no skipped or repeated values.
- RUN, last ball: on the edge where ballValid=1 and ballsDropped==NUM_BALLS-1, ballsDropped becomes NUM_BALLS and state becomes DONE.
  - ballValid is therefore high for exactly NUM_BALLS cycles per run.
- Ignored inputs:
  - start during RUN.
  - seedLoad during RUN (the LFSR is not disturbed).
- DONE: done=1, busy=0, ballValid=0; ballsDropped holds NUM_BALLS.
- Latency: start edge -> first ballValid=1 in the next cycle.
- Widths: ballsDropped is an 8-bit unsigned counter that never wraps, since the run stops at NUM_BALLS.

Decomposition:
- Shared package plinko_pkg holds:
  - RAND_W=7 and NUM_BINS=8
  - the dropper state enum (IDLE/RUN/DONE)
  - the LFSR tap constant
  - the zero-seed substitute value 7'h01
- One sub-module, lfsr7, with ports clk, rst, advance, load, loadVal and q, plus the SEED parameter.
- Control FSM and counter stay in ball_dropper.

Test Plan:
1. Reset, then hold idle -> randChoice=7'h5A, ballValid=0, busy=0, done=0, ballsDropped=0.
2. seedLoad with seedIn=7'h01, then start -> ball values 01,02,04,08,10,20,41,03 on consecutive cycles; busy=1.
3. Run with NUM_BALLS=80 -> ballValid high exactly 80 cycles, then done=1, busy=0, ballsDropped=80. Rerun with NUM_BALLS=127 -> all 127 values distinct and nonzero.
4. pause high for 3 cycles after ball 10 -> ballValid=0 and randChoice frozen for 3 cycles; ball 11 is the LFSR successor of ball 10; total stays 80.
5. seedLoad with seedIn=0 in IDLE -> q=7'h01. seedLoad with seedIn=7'h33 mid-RUN -> sequence unchanged. start mid-RUN -> ballsDropped not cleared.
6. Assert rst between edges after ball 40 -> immediately ballValid=0, busy=0, randChoice=7'h5A, ballsDropped=0. A following start yields first ball 7'h5A.
